// File: rtl/bw_pkg.sv
// bw_pkg: shared FSM encoding, default widths and counter sizing for the
// Baugh-Wooley multiplier/divider datapaths.
package bw_pkg;
   typedef enum logic [1:0] {IDLE, ABS, DIV, FIX} state_e;
   localparam int BW_DW = 12;
   localparam int BW_VW = 5;
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division iteration; shifts the next dividend
// bit into the partial remainder and subtracts |b| when it fits.
module div_restore_step #(
   parameter int VW = 5
) (
   input  logic [VW:0]   pr_i,
   input  logic [VW-1:0] bmag_i,
   input  logic          bit_i,
   output logic [VW:0]   pr_o,
   output logic          q_o
);
   logic [VW:0] t;
   always_comb begin
      t = {pr_i[VW-1:0], bit_i};
      q_o = (t >= {1'b0, bmag_i});
      pr_o = q_o ? t - {1'b0, bmag_i} : t;
   end
endmodule

// File: rtl/bw_seq_divider.sv
// bw_seq_divider: sequential signed restoring divider, truncating quotient.
// Define BW_DIV_DVZ_EN to short-circuit zero divisors and raise dvz.
module bw_seq_divider
   import bw_pkg::*;
#(
   parameter int DW = BW_DW,
   parameter int VW = BW_VW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          dvz
);
   localparam int CW = cnt_w(DW);
   state_e        state_q, state_d;
   logic [DW-1:0] amag_q, amag_d, quotient_q, quotient_d;
   logic [VW-1:0] bmag_q, bmag_d, remainder_q, remainder_d;
   logic [VW:0]   pr_q, pr_d, step_pr, rfix;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sq_q, sq_d, sr_q, sr_d, done_q, done_d, dvz_q, dvz_d, step_q, dz;
`ifdef BW_DIV_DVZ_EN
   assign dz = (bmag_q == '0);
`else
   assign dz = 1'b0;
`endif
   // amag_q holds the raw dividend, then |a|, then shifts quotient bits in as a's bits shift out
   div_restore_step #(.VW(VW)) u_step (
      .pr_i(pr_q), .bmag_i(bmag_q), .bit_i(amag_q[DW-1]), .pr_o(step_pr), .q_o(step_q)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == IDLE) ? (start ? ABS : IDLE) :
                (state_q == ABS)  ? (dz ? FIX : DIV) :
                (state_q == DIV)  ? ((cnt_q == '0) ? FIX : DIV) : IDLE;
   end
   always_comb begin
      amag_d = amag_q;
      bmag_d = bmag_q;
      pr_d = pr_q;
      cnt_d = cnt_q;
      sq_d = sq_q;
      sr_d = sr_q;
      quotient_d = quotient_q;
      remainder_d = remainder_q;
      done_d = 1'b0;
      dvz_d = dvz_q;
      rfix = sr_q ? -pr_q : pr_q;
      if (state_q == IDLE && start) begin
         amag_d = dividend;
         bmag_d = divisor;
         sq_d = dividend[DW-1] ^ divisor[VW-1];
         sr_d = dividend[DW-1];
         dvz_d = 1'b0;
      end
      if (state_q == ABS) begin
         amag_d = sr_q ? -amag_q : amag_q;
         bmag_d = bmag_q[VW-1] ? -bmag_q : bmag_q;
         pr_d = '0;
         cnt_d = CW'(DW - 1);
      end
      if (state_q == DIV) begin
         pr_d = step_pr;
         amag_d = {amag_q[DW-2:0], step_q};
         cnt_d = cnt_q - CW'(1);
      end
      if (state_q == FIX) begin
         quotient_d = dz ? '0 : (sq_q ? -amag_q : amag_q);
         remainder_d = dz ? '0 : rfix[VW-1:0];
         dvz_d = dz;
         done_d = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         amag_q <= '0;
         bmag_q <= '0;
         pr_q <= '0;
         cnt_q <= '0;
         sq_q <= 1'b0;
         sr_q <= 1'b0;
         quotient_q <= '0;
         remainder_q <= '0;
         done_q <= 1'b0;
         dvz_q <= 1'b0;
      end else begin
         amag_q <= amag_d;
         bmag_q <= bmag_d;
         pr_q <= pr_d;
         cnt_q <= cnt_d;
         sq_q <= sq_d;
         sr_q <= sr_d;
         quotient_q <= quotient_d;
         remainder_q <= remainder_d;
         done_q <= done_d;
         dvz_q <= dvz_d;
      end
   end
   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign quotient = quotient_q;
   assign remainder = remainder_q;
   assign dvz = dvz_q;
endmodule
